// File: rtl/dma_spi.sv
// SPI-slave receiver for the 408-bit timing/synthesiser control frame.
// Oversamples SCLK/CS/MOSI in the clk domain and publishes the decoded fields with one-cycle strobes.
module dma_spi (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        MOSI,
  input  logic        CS,
  input  logic        SCLK,
  output logic [63:0] TIME,
  output logic        SYS_TIME_UPDATE,
  output logic [47:0] FREQ,
  output logic [47:0] FREQ_STEP,
  output logic [31:0] FREQ_RATE,
  output logic [63:0] TIME_START,
  output logic [15:0] N_impulse,
  output logic [7:0]  TYPE_impulse,
  output logic [31:0] Interval_Ti,
  output logic [31:0] Interval_Tp,
  output logic [31:0] Tblank1,
  output logic [31:0] Tblank2,
  output logic        SPI_WR,
  output logic        RESET_WCW
);

  localparam logic [8:0] FrameBits = 9'd408;
  localparam logic [8:0] CntMax    = 9'd511;

  logic [1:0]   mosiSync_q;
  logic [2:0]   sclkSync_q;
  logic [2:0]   csSync_q;
  logic [407:0] shift_q, shift_d;
  logic [8:0]   bitCnt_q, bitCnt_d;
  logic         armed_q, armed_d;

  logic [63:0]  timeVal_q;
  logic [47:0]  freq_q;
  logic [47:0]  freqStep_q;
  logic [31:0]  freqRate_q;
  logic [63:0]  timeStart_q;
  logic [15:0]  nImpulse_q;
  logic [7:0]   typeImpulse_q;
  logic [31:0]  intervalTi_q;
  logic [31:0]  intervalTp_q;
  logic [31:0]  tblank1_q;
  logic [31:0]  tblank2_q;
  logic         spiWr_q, spiWr_d;
  logic         sysTimeUpd_q, sysTimeUpd_d;
  logic         resetWcw_q, resetWcw_d;

  logic sclkRise;
  logic csRise;
  logic csFall;
  logic shiftEn;
  logic commitOk;
  logic isResetCmd;

  assign sclkRise = sclkSync_q[1] & ~sclkSync_q[2];
  assign csRise   = csSync_q[1] & ~csSync_q[2];
  assign csFall   = ~csSync_q[1] & csSync_q[2];
  // A bit arriving together with the CS release still belongs to the frame.
  assign shiftEn  = sclkRise & armed_q & (~csSync_q[1] | csRise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosiSync_q <= '0;
      sclkSync_q <= '0;
      csSync_q   <= '0;
    end else if (clk_en) begin
      mosiSync_q <= {mosiSync_q[0], MOSI};
      sclkSync_q <= {sclkSync_q[1:0], SCLK};
      csSync_q   <= {csSync_q[1:0], CS};
    end
  end

  // armed_q is only set by a CS falling edge, so a frame interrupted by reset cannot commit.
  always_comb begin
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    armed_d  = armed_q;
    if (shiftEn) begin
      shift_d = {shift_q[406:0], mosiSync_q[1]};
      if (bitCnt_q != CntMax) bitCnt_d = bitCnt_q + 9'd1;
    end
    if (csFall) begin
      bitCnt_d = '0;
      armed_d  = 1'b1;
    end
    if (csRise) armed_d = 1'b0;
  end

  assign commitOk   = csRise & armed_q & (bitCnt_d == FrameBits);
  assign isResetCmd = (shift_d[135:128] == 8'hFF);

  always_comb begin
    spiWr_d      = commitOk & ~isResetCmd;
    sysTimeUpd_d = commitOk & ~isResetCmd & (shift_d[407:344] != 64'd0);
    resetWcw_d   = commitOk & isResetCmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      armed_q  <= 1'b0;
    end else if (clk_en) begin
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      armed_q  <= armed_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spiWr_q      <= 1'b0;
      sysTimeUpd_q <= 1'b0;
      resetWcw_q   <= 1'b0;
    end else if (clk_en) begin
      spiWr_q      <= spiWr_d;
      sysTimeUpd_q <= sysTimeUpd_d;
      resetWcw_q   <= resetWcw_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeVal_q     <= '0;
      freq_q        <= '0;
      freqStep_q    <= '0;
      freqRate_q    <= '0;
      timeStart_q   <= '0;
      nImpulse_q    <= '0;
      typeImpulse_q <= '0;
      intervalTi_q  <= '0;
      intervalTp_q  <= '0;
      tblank1_q     <= '0;
      tblank2_q     <= '0;
    end else if (clk_en && spiWr_d) begin
      timeVal_q     <= shift_d[407:344];
      freq_q        <= shift_d[343:296];
      freqStep_q    <= shift_d[295:248];
      freqRate_q    <= shift_d[247:216];
      timeStart_q   <= shift_d[215:152];
      nImpulse_q    <= shift_d[151:136];
      typeImpulse_q <= shift_d[135:128];
      intervalTi_q  <= shift_d[127:96];
      intervalTp_q  <= shift_d[95:64];
      tblank1_q     <= shift_d[63:32];
      tblank2_q     <= shift_d[31:0];
    end
  end

  assign TIME            = timeVal_q;
  assign FREQ            = freq_q;
  assign FREQ_STEP       = freqStep_q;
  assign FREQ_RATE       = freqRate_q;
  assign TIME_START      = timeStart_q;
  assign N_impulse       = nImpulse_q;
  assign TYPE_impulse    = typeImpulse_q;
  assign Interval_Ti     = intervalTi_q;
  assign Interval_Tp     = intervalTp_q;
  assign Tblank1         = tblank1_q;
  assign Tblank2         = tblank2_q;
  assign SPI_WR          = spiWr_q;
  assign SYS_TIME_UPDATE = sysTimeUpd_q;
  assign RESET_WCW       = resetWcw_q;

endmodule

// File: tb/tb_dma_spi.sv
// Self-checking bench for dma_spi: drives SPI frames at SCLK = clk/2 and compares
// the decoded fields and strobe counts against a frame-level reference model.
module tb_dma_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        MOSI;
  logic        CS;
  logic        SCLK;
  logic [63:0] TIME;
  logic        SYS_TIME_UPDATE;
  logic [47:0] FREQ;
  logic [47:0] FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [7:0]  TYPE_impulse;
  logic [31:0] Interval_Ti;
  logic [31:0] Interval_Tp;
  logic [31:0] Tblank1;
  logic [31:0] Tblank2;
  logic        SPI_WR;
  logic        RESET_WCW;

  dma_spi dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .MOSI(MOSI), .CS(CS), .SCLK(SCLK),
    .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
    .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
    .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
    .Tblank1(Tblank1), .Tblank2(Tblank2),
    .SPI_WR(SPI_WR), .RESET_WCW(RESET_WCW)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Strobe monitor: counts pulses, flags any strobe wider than one clk.
  int   cycle = 0;
  int   wrCount = 0, sysCount = 0, rstCount = 0, wideErr = 0;
  int   lastWrCycle = 0, csRiseCycle = 0;
  logic prevWr = 1'b0, prevSys = 1'b0, prevRst = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (SPI_WR === 1'b1) begin
      wrCount++;
      lastWrCycle = cycle;
      if (prevWr) wideErr++;
    end
    if (SYS_TIME_UPDATE === 1'b1) begin
      sysCount++;
      if (prevSys) wideErr++;
    end
    if (RESET_WCW === 1'b1) begin
      rstCount++;
      if (prevRst) wideErr++;
    end
    prevWr  = (SPI_WR === 1'b1);
    prevSys = (SYS_TIME_UPDATE === 1'b1);
    prevRst = (RESET_WCW === 1'b1);
  end

  // Reference model state: what the field outputs and strobe totals should be.
  logic [407:0] expOut = '0;
  int expWr = 0, expSys = 0, expRst = 0;

  function automatic logic [407:0] actualOut();
    return {TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
            Interval_Ti, Interval_Tp, Tblank1, Tblank2};
  endfunction

  function automatic logic [407:0] makeFrame(
    input logic [63:0] t, input logic [47:0] f, input logic [47:0] fs,
    input logic [31:0] fr, input logic [63:0] ts, input logic [15:0] n,
    input logic [7:0] ty, input logic [31:0] ti, input logic [31:0] tp,
    input logic [31:0] b1, input logic [31:0] b2);
    return {t, f, fs, fr, ts, n, ty, ti, tp, b1, b2};
  endfunction

  // Only a CS-framed transfer of exactly 408 bits with the block enabled takes effect.
  function automatic void modelFrame(input logic [407:0] f, input int nbits, input logic en);
    logic [7:0]  ty;
    logic [63:0] t;
    ty = f[135:128];
    t  = f[407:344];
    if (en && nbits == 408) begin
      if (ty == 8'hFF) expRst++;
      else begin
        expOut = f;
        expWr++;
        if (t != 64'd0) expSys++;
      end
    end
  endfunction

  task automatic csLow();
    @(negedge clk);
    CS = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic shiftBits(input logic [407:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      SCLK = 1'b0;
      if (i < 408) MOSI = f[407 - i];
      else         MOSI = 1'($urandom);
      @(negedge clk);
      SCLK = 1'b1;
    end
    @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic csHigh();
    @(negedge clk);
    CS = 1'b1;
    csRiseCycle = cycle;
    repeat (8) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [407:0] f, input int nbits);
    csLow();
    shiftBits(f, nbits);
    csHigh();
    modelFrame(f, nbits, clk_en);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({actualOut(), SPI_WR, SYS_TIME_UPDATE, RESET_WCW} !== 411'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs_in_reset: got %h required 0", {actualOut(), SPI_WR, SYS_TIME_UPDATE, RESET_WCW});
    end
    rst_n = 1'b1;
    expOut = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    applyReset();
    testsRun++;
    if (actualOut() !== 408'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_fields_after_release: got %h required 0", actualOut());
    end
    testsRun++;
    if (wrCount + sysCount + rstCount !== 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_strobes: got %0d pulses required 0", wrCount + sysCount + rstCount);
    end
  endtask

  task automatic test_valid_frame();
    logic [407:0] f;
    f = makeFrame(64'd1, 48'h280000000000, 48'h2cbd3f, 32'd1, 64'd50000, 16'd10, 8'd0,
                  32'd100, 32'd100, 32'd10, 32'd5);
    sendFrame(f, 408);
    testsRun++;
    if (actualOut() !== f) begin
      testsFailed++;
      $display("[TB] FAIL valid_fields: got %h required %h", actualOut(), f);
    end
    testsRun++;
    if (wrCount !== 1 || sysCount !== 1) begin
      testsFailed++;
      $display("[TB] FAIL valid_strobes: got wr=%0d sys=%0d required wr=1 sys=1", wrCount, sysCount);
    end
    testsRun++;
    if (lastWrCycle - csRiseCycle < 1 || lastWrCycle - csRiseCycle > 4) begin
      testsFailed++;
      $display("[TB] FAIL valid_latency: got %0d clk required 1..4", lastWrCycle - csRiseCycle);
    end
  endtask

  task automatic test_time_zero();
    logic [407:0] f1, f2;
    int sys0;
    sys0 = sysCount;
    f1 = makeFrame(64'd0, 48'h123456789abc, 48'h10, 32'd7, 64'd24000, 16'd3, 8'd2,
                   32'd11, 32'd22, 32'd33, 32'd44);
    f2 = makeFrame(64'd0, 48'h123456789abc, 48'h10, 32'd7, 64'd48000, 16'd3, 8'd2,
                   32'd11, 32'd22, 32'd33, 32'd44);
    sendFrame(f1, 408);
    testsRun++;
    if (TIME_START !== 64'd24000 || TIME !== 64'd0) begin
      testsFailed++;
      $display("[TB] FAIL time0_first: got TIME_START=%0d TIME=%0d required 24000/0", TIME_START, TIME);
    end
    sendFrame(f2, 408);
    testsRun++;
    if (TIME_START !== 64'd48000 || actualOut() !== f2) begin
      testsFailed++;
      $display("[TB] FAIL time0_second: got TIME_START=%0d required 48000", TIME_START);
    end
    testsRun++;
    if (wrCount !== expWr || sysCount !== sys0) begin
      testsFailed++;
      $display("[TB] FAIL time0_strobes: got wr=%0d sys=%0d required wr=%0d sys=%0d", wrCount, sysCount, expWr, sys0);
    end
  endtask

  task automatic test_bad_length();
    logic [407:0] f;
    int wr0;
    wr0 = wrCount;
    f = makeFrame(64'hdead, 48'h1, 48'h2, 32'd3, 64'd4, 16'd5, 8'd6, 32'd7, 32'd8, 32'd9, 32'd10);
    sendFrame(f, 407);
    testsRun++;
    if (actualOut() !== expOut || wrCount !== wr0) begin
      testsFailed++;
      $display("[TB] FAIL short_frame: got wr=%0d out=%h required wr=%0d out=%h", wrCount, actualOut(), wr0, expOut);
    end
    sendFrame(f, 409);
    testsRun++;
    if (actualOut() !== expOut || wrCount !== wr0) begin
      testsFailed++;
      $display("[TB] FAIL long_frame: got wr=%0d out=%h required wr=%0d out=%h", wrCount, actualOut(), wr0, expOut);
    end
  endtask

  task automatic test_reset_cmd();
    logic [407:0] f;
    int wr0, rst0;
    wr0 = wrCount;
    rst0 = rstCount;
    f = makeFrame(64'd99, 48'h5, 48'h6, 32'd7, 64'd8, 16'd9, 8'hFF, 32'd1, 32'd2, 32'd3, 32'd4);
    sendFrame(f, 408);
    testsRun++;
    if (rstCount !== rst0 + 1) begin
      testsFailed++;
      $display("[TB] FAIL resetcmd_pulse: got %0d pulses required %0d", rstCount - rst0, 1);
    end
    testsRun++;
    if (actualOut() !== expOut || wrCount !== wr0) begin
      testsFailed++;
      $display("[TB] FAIL resetcmd_fields: got wr=%0d out=%h required wr=%0d out=%h", wrCount, actualOut(), wr0, expOut);
    end
  endtask

  task automatic test_reset_midframe();
    logic [407:0] f, g;
    int wr0;
    f = makeFrame(64'd5, 48'h7, 48'h8, 32'd9, 64'd10, 16'd11, 8'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    g = makeFrame(64'd77, 48'habc, 48'hdef, 32'd12, 64'd34, 16'd56, 8'd3, 32'd78, 32'd90, 32'd13, 32'd14);
    csLow();
    shiftBits(f, 200);
    applyReset();
    wr0 = wrCount;
    // CS stays low through reset; 408 bits without a new falling edge must not commit.
    shiftBits(g, 408);
    csHigh();
    testsRun++;
    if (wrCount !== wr0 || actualOut() !== 408'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_orphan: got wr=%0d out=%h required wr=%0d out=0", wrCount, actualOut(), wr0);
    end
    sendFrame(g, 408);
    testsRun++;
    if (actualOut() !== g || wrCount !== wr0 + 1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_commit: got wr=%0d out=%h required wr=%0d out=%h", wrCount, actualOut(), wr0 + 1, g);
    end
    expWr = wrCount;
    expSys = sysCount;
    expRst = rstCount;
  endtask

  task automatic test_clk_en();
    logic [407:0] f;
    f = makeFrame(64'd1, 48'h1, 48'h1, 32'd1, 64'd1, 16'd1, 8'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge clk);
    clk_en = 1'b0;
    sendFrame(f, 408);
    @(negedge clk);
    clk_en = 1'b1;
    repeat (6) @(negedge clk);
    testsRun++;
    if (actualOut() !== expOut || wrCount !== expWr) begin
      testsFailed++;
      $display("[TB] FAIL clken_freeze: got wr=%0d out=%h required wr=%0d out=%h", wrCount, actualOut(), expWr, expOut);
    end
  endtask

  task automatic test_random_frames();
    logic [407:0] f;
    int nbits;
    for (int k = 0; k < 10; k++) begin
      for (int w = 0; w < 13; w++) f[w*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) f[135:128] = 8'hFF;
      if ($urandom_range(0, 3) == 0) f[407:344] = 64'd0;
      case ($urandom_range(0, 5))
        0:       nbits = 407;
        1:       nbits = 409;
        default: nbits = 408;
      endcase
      sendFrame(f, nbits);
      testsRun++;
      if (actualOut() !== expOut) begin
        testsFailed++;
        $display("[TB] FAIL random_fields[%0d]: got %h required %h", k, actualOut(), expOut);
      end
      testsRun++;
      if (wrCount !== expWr || sysCount !== expSys || rstCount !== expRst) begin
        testsFailed++;
        $display("[TB] FAIL random_strobes[%0d]: got wr=%0d sys=%0d rst=%0d required %0d/%0d/%0d",
                 k, wrCount, sysCount, rstCount, expWr, expSys, expRst);
      end
    end
  endtask

  task automatic test_strobe_width();
    testsRun++;
    if (wideErr !== 0) begin
      testsFailed++;
      $display("[TB] FAIL strobe_width: got %0d wide pulses required 0", wideErr);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    clk_en = 1'b1;
    MOSI   = 1'b0;
    CS     = 1'b1;
    SCLK   = 1'b0;
    test_reset();
    test_valid_frame();
    test_time_zero();
    test_bad_length();
    test_reset_cmd();
    test_reset_midframe();
    test_clk_en();
    test_random_frames();
    test_strobe_width();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
